// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: access size encoding,
// per-port request bundle and the access-size-to-byte-count helper.
package dmem_arb_pkg;

  // Address width carried in the request bundle; the arbiter top checks that
  // its DMEM_ADDR_WIDTH parameter matches it.
  localparam int ARB_ADDR_W = 12;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } sz_e;

  // sz stays a raw 2-bit field so that the 2'b11 encoding (also a word) passes through untouched.
  typedef struct packed {
    logic                  we;
    logic [1:0]            sz;
    logic [ARB_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } dmem_req_t;

  function automatic logic [2:0] bytes_of(input logic [1:0] sz);
    if (sz[1])                bytes_of = 3'd4;
    else if (sz == SZ_HALF)   bytes_of = 3'd2;
    else                      bytes_of = 3'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port response stage: registers rvalid/rdata/err one cycle after a grant.
// Writes and errored accesses return zero data.
module dmem_arb_resp
  import dmem_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        grant,
  input  logic        we,
  input  logic        err_comb,
  input  logic [31:0] mem_dout,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= grant;
      err    <= grant & err_comb;
      rdata  <= (grant && !we && !err_comb) ? mem_dout : '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the shared data memory: fixed core priority with a
// starvation counter. Optional range checking under `DMEM_ARB_RANGE_CHK_EN`.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DMEM_DEPTH      = 1024,
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int MAX_WAIT        = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       c_req_i,
  input  logic                       c_we_i,
  input  logic [1:0]                 c_sz_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] c_addr_i,
  input  logic [31:0]                c_wdata_i,
  output logic                       c_gnt_o,
  output logic                       c_rvalid_o,
  output logic [31:0]                c_rdata_o,
  output logic                       c_err_o,
  input  logic                       d_req_i,
  input  logic                       d_we_i,
  input  logic [1:0]                 d_sz_i,
  input  logic [DMEM_ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]                d_wdata_i,
  output logic                       d_gnt_o,
  output logic                       d_rvalid_o,
  output logic [31:0]                d_rdata_o,
  output logic                       d_err_o,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                       mem_rd_en_o,
  output logic                       mem_wr_en_o,
  output logic [1:0]                 mem_sz_o,
  output logic [31:0]                mem_din_o,
  input  logic [31:0]                mem_dout_i
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  if (MAX_WAIT < 1)                            $error("MAX_WAIT must be >= 1");
  if (DMEM_ADDR_WIDTH != ARB_ADDR_W)           $error("DMEM_ADDR_WIDTH must match the request bundle width");
  if (4 * DMEM_DEPTH > (1 << DMEM_ADDR_WIDTH)) $error("address width cannot reach the whole memory");

  logic [WCW-1:0] wait_cnt;
  logic           force_d;
  logic           gnt;
  logic           oor;
  dmem_req_t      c_req, d_req, sel;

  assign c_req = '{we: c_we_i, sz: c_sz_i, addr: c_addr_i, wdata: c_wdata_i};
  assign d_req = '{we: d_we_i, sz: d_sz_i, addr: d_addr_i, wdata: d_wdata_i};

  // Grants are held off while reset is asserted so no access reaches the memory.
  assign force_d = d_req_i & (wait_cnt == WCW'(MAX_WAIT));
  assign d_gnt_o = ~rst_i & d_req_i & (force_d | ~c_req_i);
  assign c_gnt_o = ~rst_i & c_req_i & ~d_gnt_o;
  assign gnt     = c_gnt_o | d_gnt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        wait_cnt <= '0;
    else if (!d_req_i || d_gnt_o)     wait_cnt <= '0;
    else if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  // NOTE: default assigned first, so no path through this block can infer a latch.
  always_comb begin
    sel = '0;
    if (d_gnt_o)      sel = d_req;
    else if (c_gnt_o) sel = c_req;
  end

`ifdef DMEM_ARB_RANGE_CHK_EN
  // One extra bit so an end address past the top of the address space is not lost to wrap.
  logic [DMEM_ADDR_WIDTH:0] last_byte;
  assign last_byte = {1'b0, sel.addr} + (DMEM_ADDR_WIDTH+1)'(bytes_of(sel.sz))
                   - (DMEM_ADDR_WIDTH+1)'(1);
  assign oor = gnt & (32'(last_byte) >= 32'(4 * DMEM_DEPTH));
`else
  assign oor = 1'b0;
`endif

  assign mem_addr_o  = sel.addr;
  assign mem_sz_o    = sel.sz;
  assign mem_din_o   = sel.wdata;
  assign mem_rd_en_o = gnt & ~sel.we & ~oor;
  assign mem_wr_en_o = gnt &  sel.we & ~oor;

  dmem_arb_resp u_c_resp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .grant    (c_gnt_o),
    .we       (c_we_i),
    .err_comb (oor),
    .mem_dout (mem_dout_i),
    .rvalid   (c_rvalid_o),
    .rdata    (c_rdata_o),
    .err      (c_err_o)
  );

  dmem_arb_resp u_d_resp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .grant    (d_gnt_o),
    .we       (d_we_i),
    .err_comb (oor),
    .mem_dout (mem_dout_i),
    .rvalid   (d_rvalid_o),
    .rdata    (d_rdata_o),
    .err      (d_err_o)
  );

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single banked, byte-addressable data memory between the core load/store unit (port C) and the DMA/debug engine (port D). Core has fixed priority. A saturating starvation counter forces a DMA grant after MAX_WAIT contended cycles. The block forwards one access per cycle to the memory and returns a registered response one cycle after each grant. It sits between the core/DMA and the data memory, whose read is combinational and whose write is clocked.

Parameters:
DMEM_DEPTH, 1024, memory depth in 32-bit words (byte capacity = 4*DMEM_DEPTH)
DMEM_ADDR_WIDTH, 12, byte-address width of all address ports
MAX_WAIT, 4, contended cycles DMA may lose before it is forced a grant; legal range >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
c_req_i  in  1  core request
c_we_i  in  1  core write (1) / read (0)
c_sz_i  in  2  00 byte, 01 half, 1x word
c_addr_i  in  DMEM_ADDR_WIDTH  core byte address (unaligned allowed)
c_wdata_i  in  32  core store data, LSB-justified
c_gnt_o  out  1  core request accepted this cycle
c_rvalid_o  out  1  core response valid
c_rdata_o  out  32  core read data
c_err_o  out  1  core access error (see Optional Feature)
d_req_i, d_we_i, d_sz_i, d_addr_i, d_wdata_i, d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o: same widths and meaning, DMA port
mem_addr_o  out  DMEM_ADDR_WIDTH  memory byte address
mem_rd_en_o  out  1  memory read enable
mem_wr_en_o  out  1  memory write enable
mem_sz_o  out  2  memory access size
mem_din_o  out  32  memory write data
mem_dout_i  in  32  memory read data (combinational, same cycle)

Behaviour:
- Grant logic is combinational, with at most one grant per cycle:
  - force = d_req_i & (wait_cnt == MAX_WAIT)
  - d_gnt_o = d_req_i & (force | ~c_req_i)
  - c_gnt_o = c_req_i & ~d_gnt_o
- wait_cnt has width $clog2(MAX_WAIT+1) and is reset to 0.
  - Increments, saturating at MAX_WAIT, when d_req_i & ~d_gnt_o.
  - Cleared on d_gnt_o or when d_req_i is low.
- Memory side, for the granted port g:
  - mem_addr_o, mem_sz_o and mem_din_o come from port g.
  - mem_rd_en_o = gnt & ~we_g; mem_wr_en_o = gnt & we_g.
  - With no grant, mem_addr_o, mem_sz_o and mem_din_o are 0 and both enables are 0.
- Requester handshake:
  - Request fields must stay stable while req is high and gnt is low.
  - A request completes on the cycle req & gnt are both high.
  - A new request may be presented the next cycle, giving full throughput of one access per cycle.
- Response timing:
  - At the posedge ending a grant cycle, the granted port's rvalid register is set for exactly 1 cycle.
  - Read: rdata is registered from mem_dout_i.
  - Write: rdata = 0, rvalid = 1 (write acknowledge).
  - Latency from grant to rvalid is 1 cycle.
  - The rvalid of the non-granted port is 0. Both ports can never have rvalid set in the same cycle.
- Reset values: c/d_rvalid_o = 0, c/d_rdata_o = 0, c/d_err_o = 0, wait_cnt = 0.
  - Reset asserted mid-operation drops any pending response; no rvalid is issued after reset.
- Simultaneous requests with wait_cnt < MAX_WAIT: core wins and wait_cnt increments.
- MAX_WAIT=1: under continuous contention, grants alternate C, D, C, D, and so on.
- The arbiter never modifies sz, address alignment, or data lane positions. Byte-lane rotation is done by the memory.

Optional Feature:
Macro: DMEM_ARB_RANGE_CHK_EN
- Defined:
  - An access whose last byte, addr + bytes(sz) - 1, is >= 4*DMEM_DEPTH is still granted, but mem_rd_en_o and mem_wr_en_o stay 0.
  - The next cycle, the response has rvalid = 1, err = 1 and rdata = 0.
  - In-range accesses respond with err = 0.
  - The end-address sum is computed one bit wider than DMEM_ADDR_WIDTH so that wrap-around is detected.
- Not defined: c_err_o and d_err_o are tied to 0, and addresses wrap inside the memory.

Decomposition:
- Package dmem_arb_pkg holds:
  - the size enum: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10
  - a request struct {we, sz, addr, wdata}
  - the function bytes_of(sz)
- Sub-module dmem_arb_resp: one instance per port. Each instance holds the rvalid/rdata/err registers and takes inputs grant, we, err_comb and mem_dout.

Test Plan:
- C only: read, addr=0x004, sz=word, mem_dout=0xDEADBEEF -> c_gnt same cycle; mem_rd_en=1; next cycle c_rvalid=1, c_rdata=0xDEADBEEF; d_rvalid=0.
- Contention, MAX_WAIT=4, both ports requesting continuously for 10 cycles -> grant sequence C,C,C,C,D,C,C,C,C,D; wait_cnt returns to 0 after each D grant.
- D only: write, addr=0x013, sz=half, wdata=0x0000A5A5 -> mem_wr_en=1, mem_addr=0x013, mem_sz=01; next cycle d_rvalid=1, d_rdata=0.
- Back-to-back C requests (write 0x100, then read 0x100) -> gnt in 2 consecutive cycles; rvalid in 2 consecutive cycles; read returns the written data.
- rst_i asserted in the cycle after a grant -> c_rvalid stays 0; wait_cnt=0; all mem enables 0 during reset.
- With DMEM_ARB_RANGE_CHK_EN: word read at 0xFFE (DMEM_DEPTH=1024) -> gnt=1, mem_rd_en=0; next cycle rvalid=1, err=1, rdata=0. Byte read at 0xFFF -> err=0.
